// File: rtl/dp_ram_fwd_if.sv
`default_nettype none
// ============================================================================
//  Module   : dp_ram_fwd_if
//  Brief    : Write/read/clear bundle for the dual-port forwarding RAM.
//  Revision : 1.0 - initial release
// ============================================================================
interface dp_ram_fwd_if #(
    parameter int PS = 8,
    parameter int NP = 8,
    parameter int AW = 12
);
    localparam int DW = NP * PS;

    logic [DW-1:0] wd;
    logic [AW-1:0] wa;
    logic          we;
    logic [NP-1:0] wbe;
    logic [AW-1:0] ra;
    logic          re;
    logic [DW-1:0] rd;
    logic          rd_valid;
    logic          clear;
    logic          busy;

    modport master (
        output wd, wa, we, wbe, ra, re, clear,
        input  rd, rd_valid, busy
    );

    modport slave (
        input  wd, wa, we, wbe, ra, re, clear,
        output rd, rd_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/dp_ram_fwd.sv
`default_nettype none
// ============================================================================
//  Module   : dp_ram_fwd
//  Brief    : Simple dual-port lane-enabled RAM with 1/2-cycle read latency,
//             collision bypass and a sequential clear engine.
//  Revision : 1.0 - initial release
// ============================================================================
module dp_ram_fwd #(
    parameter int PS             = 8,
    parameter int NP             = 8,
    parameter int DW             = NP * PS,
    parameter int DEPTH          = 2 * 720 * 16 / NP,
    parameter int AW             = $clog2(DEPTH),
    parameter int RD_LAT         = 1,
    parameter int WR_FIRST       = 1,
    parameter int CLEAR_ON_RESET = 0
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    dp_ram_fwd_if.slave bus
);
    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_CLEAR = 1'b1;
    localparam logic [AW:0]   c_depth = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);

    logic [DW-1:0] r_mem [DEPTH];

    logic [0:0]    r_state, w_state_nxt;
    logic [AW-1:0] r_ptr, w_ptr_nxt;
    logic          r_init;
    logic          w_busy;

    logic          w_wr_ok, w_rd_ok, w_ra_ok, w_coll;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_wa;
    logic [DW-1:0] w_mem_wd;
    logic [NP-1:0] w_mem_be;

    logic [DW-1:0] r_q, r_fwd_wd, w_s1_data;
    logic [NP-1:0] r_fwd_be;
    logic          r_v1;

    // r_init requests one sweep in the first cycle after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_init  <= (CLEAR_ON_RESET != 0);
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_init  <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (bus.clear || r_init) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == c_last) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // While sweeping, the clear engine owns the single write port
    always_comb begin
        w_busy  = (r_state == S_CLEAR);
        w_wr_ok = bus.we && !w_busy && ({1'b0, bus.wa} < c_depth);
        if (w_busy) begin
            w_mem_we = 1'b1;
            w_mem_wa = r_ptr;
            w_mem_wd = '0;
            w_mem_be = '1;
        end else begin
            w_mem_we = w_wr_ok;
            w_mem_wa = bus.wa;
            w_mem_wd = bus.wd;
            w_mem_be = bus.wbe;
        end
    end

    assign bus.busy = w_busy;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < NP; i++) begin
                if (w_mem_be[i]) begin
                    r_mem[w_mem_wa][i*PS +: PS] <= w_mem_wd[i*PS +: PS];
                end
            end
        end
    end

    assign w_rd_ok = bus.re && !w_busy;
    assign w_ra_ok = ({1'b0, bus.ra} < c_depth);
    assign w_coll  = (WR_FIRST != 0) && w_wr_ok && (bus.wa == bus.ra);

    // RAM reads old data; colliding write lanes are captured beside it and merged after
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q      <= '0;
            r_fwd_wd <= '0;
            r_fwd_be <= '0;
            r_v1     <= 1'b0;
        end else begin
            r_v1 <= w_rd_ok;
            if (w_rd_ok) begin
                r_q      <= w_ra_ok ? r_mem[bus.ra] : '0;
                r_fwd_wd <= bus.wd;
                r_fwd_be <= w_coll ? bus.wbe : '0;
            end
        end
    end

    always_comb begin
        w_s1_data = r_q;
        for (int i = 0; i < NP; i++) begin
            if (r_fwd_be[i]) begin
                w_s1_data[i*PS +: PS] = r_fwd_wd[i*PS +: PS];
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DW-1:0] r_rd2;
        logic          r_v2;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_rd2 <= '0;
                r_v2  <= 1'b0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_rd2 <= w_s1_data;
                end
            end
        end

        assign bus.rd       = r_rd2;
        assign bus.rd_valid = r_v2;
    end else begin : g_lat1
        assign bus.rd       = w_s1_data;
        assign bus.rd_valid = r_v1;
    end
endmodule
`default_nettype wire

// File: tb/tb_dp_ram_fwd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dp_ram_fwd
//  Brief    : Directed bench driving two configurations of dp_ram_fwd in lockstep.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dp_ram_fwd;
    localparam int PS = 8;
    localparam int NP = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [63:0] wd;
    logic [3:0]  wa, ra;
    logic [7:0]  wbe;
    logic        we, re, clear;

    dp_ram_fwd_if #(.PS(PS), .NP(NP), .AW(AW)) bus_a ();
    dp_ram_fwd_if #(.PS(PS), .NP(NP), .AW(AW)) bus_b ();

    assign bus_a.wd = wd;  assign bus_a.wa = wa;  assign bus_a.we = we;
    assign bus_a.wbe = wbe; assign bus_a.ra = ra; assign bus_a.re = re;
    assign bus_a.clear = clear;
    assign bus_b.wd = wd;  assign bus_b.wa = wa;  assign bus_b.we = we;
    assign bus_b.wbe = wbe; assign bus_b.ra = ra; assign bus_b.re = re;
    assign bus_b.clear = clear;

    // A: DEPTH 16, latency 1, write-first. B: DEPTH 12, latency 2, read-first, clear on reset.
    dp_ram_fwd #(.PS(PS), .NP(NP), .DEPTH(16), .RD_LAT(1), .WR_FIRST(1), .CLEAR_ON_RESET(0))
        u_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    dp_ram_fwd #(.PS(PS), .NP(NP), .DEPTH(12), .RD_LAT(2), .WR_FIRST(0), .CLEAR_ON_RESET(1))
        u_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [7:0]  wbe;
        logic [63:0] wd;
        logic        re;
        logic [3:0]  ra;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
    } vec_t;

    vec_t vt[11];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [3:0] a, input logic [7:0] be,
                                input logic [63:0] d, input logic r, input logic [3:0] rad,
                                input logic [63:0] ea, input logic [63:0] eb);
        vec_t v;
        v.we = w; v.wa = a; v.wbe = be; v.wd = d;
        v.re = r; v.ra = rad; v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    function automatic logic [63:0] pat(input int i);
        return 64'h0101010101010101 * 64'(i + 1);
    endfunction

    task automatic idle();
        we = 1'b0; re = 1'b0; clear = 1'b0; wbe = '0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        we = v.we; wa = v.wa; wbe = v.wbe; wd = v.wd; re = v.re; ra = v.ra;
        @(negedge clk);
        idle();
        chk($sformatf("v%0d valid_a@1", idx), 64'(bus_a.rd_valid), 64'(v.re));
        chk($sformatf("v%0d valid_b@1", idx), 64'(bus_b.rd_valid), 64'd0);
        if (v.re) chk($sformatf("v%0d rd_a", idx), bus_a.rd, v.exp_a);
        @(negedge clk);
        chk($sformatf("v%0d valid_a@2", idx), 64'(bus_a.rd_valid), 64'd0);
        chk($sformatf("v%0d valid_b@2", idx), 64'(bus_b.rd_valid), 64'(v.re));
        if (v.re) begin
            chk($sformatf("v%0d rd_b", idx), bus_b.rd, v.exp_b);
            chk($sformatf("v%0d rd_a hold", idx), bus_a.rd, v.exp_a);
        end
    endtask

    task automatic write_all();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            we = 1'b1; wa = 4'(i); wd = pat(i); wbe = 8'hFF;
        end
        @(negedge clk);
        idle();
    endtask

    // Back-to-back reads of 0..15: A answers at t=1..16, B at t=2..17
    task automatic stream_read(input bit zero_a, input bit zero_b, input string tag);
        logic ea, eb;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            ea = (t >= 1 && t <= 16);
            eb = (t >= 2 && t <= 17);
            chk($sformatf("%s t%0d valid_a", tag, t), 64'(bus_a.rd_valid), 64'(ea));
            if (ea) chk($sformatf("%s t%0d rd_a", tag, t), bus_a.rd, zero_a ? 64'd0 : pat(t - 1));
            chk($sformatf("%s t%0d valid_b", tag, t), 64'(bus_b.rd_valid), 64'(eb));
            if (eb) chk($sformatf("%s t%0d rd_b", tag, t), bus_b.rd,
                        (zero_b || (t - 2) >= 12) ? 64'd0 : pat(t - 2));
            re = (t < 16);
            ra = 4'(t);
        end
        idle();
    endtask

    // Waits (bounded) for B's busy to rise, then counts its high cycles
    task automatic busy_len_b(output int len);
        int t;
        t = 0;
        len = 0;
        while (!bus_b.busy && t < 5) begin @(negedge clk); t++; end
        while (bus_b.busy && len < 64) begin @(negedge clk); len++; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len, cnt_a, cnt_b, vcnt;

        vt[0]  = mk(1, 5, 8'hFF, 64'h0807060504030201, 0, 0, 0, 0);
        vt[1]  = mk(0, 0, 8'h00, 64'h0, 1, 5, 64'h0807060504030201, 64'h0807060504030201);
        vt[2]  = mk(1, 5, 8'h0F, {8{8'hAA}}, 0, 0, 0, 0);
        vt[3]  = mk(0, 0, 8'h00, 64'h0, 1, 5, 64'h08070605AAAAAAAA, 64'h08070605AAAAAAAA);
        vt[4]  = mk(1, 5, 8'h00, {8{8'hFF}}, 0, 0, 0, 0);
        vt[5]  = mk(0, 0, 8'h00, 64'h0, 1, 5, 64'h08070605AAAAAAAA, 64'h08070605AAAAAAAA);
        vt[6]  = mk(1, 9, 8'hFF, {8{8'h11}}, 0, 0, 0, 0);
        vt[7]  = mk(1, 9, 8'hF0, {8{8'h22}}, 1, 9, 64'h2222222211111111, 64'h1111111111111111);
        vt[8]  = mk(0, 0, 8'h00, 64'h0, 1, 9, 64'h2222222211111111, 64'h2222222211111111);
        vt[9]  = mk(1, 12, 8'hFF, {8{8'h33}}, 0, 0, 0, 0);
        vt[10] = mk(0, 0, 8'h00, 64'h0, 1, 12, {8{8'h33}}, 64'h0);

        wd = '0; wa = '0; ra = '0;
        idle();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset rd_a", bus_a.rd, 64'd0);
        chk("reset valid_a", 64'(bus_a.rd_valid), 64'd0);
        chk("reset rd_b", bus_b.rd, 64'd0);
        chk("reset valid_b", 64'(bus_b.rd_valid), 64'd0);
        chk("reset busy_a", 64'(bus_a.busy), 64'd0);
        reset_n = 1'b1;
        busy_len_b(len);
        chk("auto sweep len_b", 64'(len), 64'd12);
        chk("auto sweep busy_a", 64'(bus_a.busy), 64'd0);

        for (int i = 0; i < 11; i++) apply(vt[i], i);

        write_all();
        stream_read(1'b0, 1'b0, "stream");

        // Read of word 3 just before clear must still drain on both ports
        @(negedge clk);
        re = 1'b1; ra = 4'd3;
        @(negedge clk);
        chk("drain valid_a", 64'(bus_a.rd_valid), 64'd1);
        chk("drain rd_a", bus_a.rd, pat(3));
        re = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("drain valid_b", 64'(bus_b.rd_valid), 64'd1);
        chk("drain rd_b", bus_b.rd, pat(3));
        cnt_a = 0; cnt_b = 0; vcnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus_a.busy) cnt_a++;
            if (bus_b.busy) cnt_b++;
            if (k >= 1 && (bus_a.rd_valid || bus_b.rd_valid)) vcnt++;
            if (k == 0) begin
                we = 1'b1; wa = 4'd3; wd = {8{8'hFF}}; wbe = 8'hFF;
                re = 1'b1; ra = 4'd3; clear = 1'b1;
            end else begin
                idle();
            end
            @(negedge clk);
        end
        chk("clear busy_a cycles", 64'(cnt_a), 64'd16);
        chk("clear busy_b cycles", 64'(cnt_b), 64'd12);
        chk("valid while busy", 64'(vcnt), 64'd0);
        stream_read(1'b1, 1'b1, "postclr");

        // Reset in the middle of B's auto sweep aborts it immediately
        write_all();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        len = 0;
        while (!bus_b.busy && len < 5) begin @(negedge clk); len++; end
        repeat (6) @(negedge clk);
        chk("mid-sweep busy_b before", 64'(bus_b.busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid-sweep busy_b abort", 64'(bus_b.busy), 64'd0);
        chk("mid-sweep rd_a", bus_a.rd, 64'd0);
        chk("mid-sweep valid_b", 64'(bus_b.rd_valid), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        busy_len_b(len);
        chk("resweep len_b", 64'(len), 64'd12);
        stream_read(1'b0, 1'b1, "resweep");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
